// File: rtl/fetch_pkg.sv
// Purpose: shared defaults, FSM state encoding and entry layout for the instruction prefetch buffer.
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package fetch_pkg;

  localparam int DEPTH_DEF           = 4;
  localparam int MAX_OUTSTANDING_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // One buffered instruction: bus error flag, PC it belongs to, fetched word.
  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] rdata;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: generic synchronous FIFO with single-cycle flush and occupancy count.
// Latency: a push into an empty FIFO shows on out_vld the next cycle.
// Backpressure: pushes while full (without a pop) and pops while empty are ignored; flush wins over push.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     out_vld,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign out_vld = (count != '0);
  assign do_pop  = pop & out_vld & ~flush;
  assign do_push = push & ~flush & ((count != FULL_CNT) | do_pop);
  // Empty FIFO presents zeros so downstream fields read 0 when nothing is held.
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Purpose: instruction prefetcher issuing word fetches on a req/gnt/rvalid bus and buffering them for IF.
// Latency: a response shows on valid_o the cycle after its rvalid; a redirect flushes the buffer the same cycle.
// Backpressure: requests only issue while outstanding plus buffered entries leave room, so the buffer never overflows.
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH           = DEPTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] boot_addr_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_addr;
  logic [31:0]  held_addr;
  logic [31:0]  resp_addr;
  logic [OW-1:0] outstanding, out_nxt;
  logic [OW-1:0] discard, discard_nxt;
  logic [AW:0]  fifo_cnt, cnt_nxt;
  logic         fire, rsp_ok, drop, push, pop, fifo_vld, credit;
  fetch_entry_t push_ent, head;

  assign fire   = instr_req_o & instr_gnt_i;
  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign rsp_ok = instr_rvalid_i & (outstanding != '0);
  assign drop   = rsp_ok & (branch_i | (discard != '0));
  assign push   = rsp_ok & ~drop;
  assign valid_o = fifo_vld & ~branch_i;
  assign pop    = valid_o & ready_i;
  assign busy_o = (outstanding != '0) | instr_req_o;

  assign push_ent.err   = instr_err_i;
  assign push_ent.addr  = resp_addr;
  assign push_ent.rdata = instr_rdata_i;
  assign rdata_o = head.rdata;
  assign addr_o  = head.addr;
  assign err_o   = head.err;

  // Next-cycle occupancy, used so credit reflects this cycle's grant, response, pop and flush.
  always_comb begin
    out_nxt = outstanding;
    if (fire && !rsp_ok)      out_nxt = outstanding + OW'(1);
    else if (!fire && rsp_ok) out_nxt = outstanding - OW'(1);
    cnt_nxt = fifo_cnt;
    if (branch_i)           cnt_nxt = '0;
    else if (push && !pop)  cnt_nxt = fifo_cnt + CW'(1);
    else if (!push && pop)  cnt_nxt = fifo_cnt - CW'(1);
    credit = (int'(out_nxt) < MAX_OUTSTANDING) && ((int'(out_nxt) + int'(cnt_nxt)) < DEPTH);
  end

  // On redirect everything still in flight becomes stale; a held request adds one more when granted.
  always_comb begin
    discard_nxt = discard;
    if (branch_i) begin
      discard_nxt = out_nxt;
    end else begin
      if (state == HOLD && fire) discard_nxt = discard_nxt + OW'(1);
      if (drop)                  discard_nxt = discard_nxt - OW'(1);
    end
  end

  // Bus request outputs decoded from state; HOLD replays the address of the pre-redirect request.
  always_comb begin
    instr_req_o  = 1'b0;
    instr_addr_o = '0;
    case (state)
      ISSUE: begin
        instr_req_o  = 1'b1;
        instr_addr_o = {fetch_addr[31:2], 2'b00};
      end
      HOLD: begin
        instr_req_o  = 1'b1;
        instr_addr_o = held_addr;
      end
      default: ;
    endcase
  end

  // Next-state logic: a request, once raised, only drops after its grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_i && credit) state_nxt = ISSUE;
      ISSUE: begin
        if (branch_i && !instr_gnt_i)         state_nxt = HOLD;
        else if (instr_gnt_i && !(req_i && credit)) state_nxt = IDLE;
      end
      HOLD:  if (instr_gnt_i) state_nxt = (req_i && credit) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Fetch, held and response-tag addresses; the first entry after a redirect keeps the unaligned target.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_addr <= boot_addr_i;
      resp_addr  <= boot_addr_i;
      held_addr  <= '0;
    end else begin
      if (branch_i)                      fetch_addr <= branch_addr_i;
      else if (fire && state == ISSUE)   fetch_addr <= fetch_addr + 32'd4;
      if (state == ISSUE && branch_i && !instr_gnt_i) held_addr <= instr_addr_o;
      if (branch_i)  resp_addr <= branch_addr_i;
      else if (push) resp_addr <= {resp_addr[31:2], 2'b00} + 32'd4;
    end
  end

  // In-flight and to-be-dropped response counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      discard     <= discard_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .flush    (branch_i),
    .out_vld  (fifo_vld),
    .out_dat  (head),
    .count    (fifo_cnt)
  );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Purpose: directed self-checking bench for the prefetch buffer with a one-cycle-latency bus responder.
// Latency: responses return the cycle after grant while responses are enabled.
// Backpressure: IF-side ready and bus grant are driven per scenario.
module tb_fetch_prefetch_buffer;
  import fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] boot_addr_i;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        busy_o;

  fetch_prefetch_buffer dut (
    .CLK(CLK), .RST_N(RST_N), .boot_addr_i(boot_addr_i), .req_i(req_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .valid_o(valid_o), .ready_i(ready_i), .rdata_o(rdata_o), .addr_o(addr_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [31:0]  grants[$];
  logic [31:0]  bus_q[$];
  fetch_entry_t pops[$];
  logic         rsp_en;
  logic [31:0]  err_addr;

  logic        s_req, s_vld, s_err, s_busy;
  logic [31:0] s_addr, s_rdata, s_addr_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // One clock: snapshot and log at the falling edge, then drive the bus response after the rising edge.
  task automatic tick();
    fetch_entry_t e;
    logic [31:0]  a;
    @(negedge CLK);
    s_req = instr_req_o; s_addr = instr_addr_o; s_vld = valid_o;
    s_rdata = rdata_o; s_addr_o = addr_o; s_err = err_o; s_busy = busy_o;
    if (instr_req_o && instr_gnt_i) begin
      grants.push_back(instr_addr_o);
      bus_q.push_back(instr_addr_o);
    end
    if (valid_o && ready_i) begin
      e.err = err_o; e.addr = addr_o; e.rdata = rdata_o;
      pops.push_back(e);
    end
    @(posedge CLK);
    #1;
    if (rsp_en && bus_q.size() > 0) begin
      a = bus_q.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = dat_of(a);
      instr_err_i    = (a == err_addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
    end
  endtask

  task automatic branch_to(input logic [31:0] a);
    branch_addr_i = a;
    branch_i = 1'b1;
    tick();
    branch_i = 1'b0;
  endtask

  task automatic drain();
    req_i = 1'b0; instr_gnt_i = 1'b1; rsp_en = 1'b1; ready_i = 1'b1;
    repeat (12) tick();
  endtask

  task automatic clear_logs();
    grants.delete();
    pops.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; boot_addr_i = 32'h80; req_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
    instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    ready_i = 1'b1; rsp_en = 1'b0; err_addr = 32'h1;

    // Reset state, with req_i already high.
    repeat (2) tick();
    check_eq("rst_req", 32'(s_req), 32'd0);
    check_eq("rst_iaddr", s_addr, 32'h0);
    check_eq("rst_vld", 32'(s_vld), 32'd0);
    check_eq("rst_rdata", s_rdata, 32'h0);
    check_eq("rst_addr", s_addr_o, 32'h0);
    check_eq("rst_err", 32'(s_err), 32'd0);
    check_eq("rst_busy", 32'(s_busy), 32'd0);

    // Boot fetch stream from 0x80.
    RST_N = 1'b1; rsp_en = 1'b1;
    tick();
    tick();
    check_eq("boot_req", 32'(s_req), 32'd1);
    check_eq("boot_iaddr", s_addr, 32'h80);
    tick();
    check_eq("boot_vld_lat0", 32'(s_vld), 32'd0);
    tick();
    check_eq("boot_vld_lat1", 32'(s_vld), 32'd1);
    check_eq("boot_head_addr", s_addr_o, 32'h80);
    check_eq("boot_head_data", s_rdata, dat_of(32'h80));
    drain();
    check_eq("boot_g0", grants[0], 32'h80);
    check_eq("boot_g1", grants[1], 32'h84);
    check_eq("boot_npop", pops.size(), grants.size());
    foreach (pops[i]) check_eq("boot_seq", pops[i].addr, 32'h80 + 32'(4 * i));

    // IF stalled: issue stops at buffer depth, nothing lost afterwards.
    clear_logs();
    ready_i = 1'b0; req_i = 1'b0;
    branch_to(32'h400);
    req_i = 1'b1;
    repeat (8) tick();
    check_eq("full_ngrant", grants.size(), 32'd4);
    check_eq("full_req", 32'(s_req), 32'd0);
    check_eq("full_vld", 32'(s_vld), 32'd1);
    check_eq("full_head", s_addr_o, 32'h400);
    ready_i = 1'b1;
    repeat (6) tick();
    drain();
    check_eq("full_npop", pops.size(), grants.size());
    foreach (pops[i]) check_eq("full_seq", pops[i].addr, 32'h400 + 32'(4 * i));
    check_eq("full_data0", pops[0].rdata, dat_of(32'h400));

    // Redirect to an unaligned target with two responses still outstanding.
    clear_logs();
    rsp_en = 1'b0; req_i = 1'b1;
    branch_to(32'h500);
    repeat (3) tick();
    check_eq("br2_ngrant", grants.size(), 32'd2);
    check_eq("br2_busy", 32'(s_busy), 32'd1);
    clear_logs();
    branch_to(32'h202);
    rsp_en = 1'b1;
    repeat (6) tick();
    drain();
    check_eq("br2_g0", grants[0], 32'h200);
    check_eq("br2_g1", grants[1], 32'h204);
    check_eq("br2_p0_addr", pops[0].addr, 32'h202);
    check_eq("br2_p0_data", pops[0].rdata, dat_of(32'h200));
    check_eq("br2_p1_addr", pops[1].addr, 32'h204);
    check_eq("br2_p1_data", pops[1].rdata, dat_of(32'h204));

    // Redirect while a request waits for grant: address held, its response dropped.
    clear_logs();
    instr_gnt_i = 1'b0; req_i = 1'b1;
    branch_to(32'h90);
    tick();
    check_eq("hold_req", 32'(s_req), 32'd1);
    check_eq("hold_pre", s_addr, 32'h90);
    clear_logs();
    branch_to(32'h300);
    tick();
    check_eq("hold_addr0", s_addr, 32'h90);
    check_eq("hold_req1", 32'(s_req), 32'd1);
    tick();
    check_eq("hold_addr1", s_addr, 32'h90);
    instr_gnt_i = 1'b1;
    repeat (4) tick();
    drain();
    check_eq("hold_g0", grants[0], 32'h90);
    check_eq("hold_g1", grants[1], 32'h300);
    check_eq("hold_p0_addr", pops[0].addr, 32'h300);
    check_eq("hold_p0_data", pops[0].rdata, dat_of(32'h300));

    // Redirect in the same cycle as a response: that response is dropped.
    clear_logs();
    req_i = 1'b1;
    branch_to(32'hA00);
    repeat (4) tick();
    clear_logs();
    branch_to(32'hB00);
    repeat (4) tick();
    drain();
    check_eq("brrv_p0_addr", pops[0].addr, 32'hB00);
    check_eq("brrv_p0_data", pops[0].rdata, dat_of(32'hB00));

    // Bus error on one word only; fetching continues.
    clear_logs();
    err_addr = 32'h10; req_i = 1'b1;
    branch_to(32'h10);
    repeat (3) tick();
    drain();
    check_eq("err_p0_addr", pops[0].addr, 32'h10);
    check_eq("err_p0_err", 32'(pops[0].err), 32'd1);
    check_eq("err_p1_addr", pops[1].addr, 32'h14);
    check_eq("err_p1_err", 32'(pops[1].err), 32'd0);
    err_addr = 32'h1;

    // Redirect with a full buffer: valid_o low in the flush cycle, old entries gone.
    clear_logs();
    ready_i = 1'b0; req_i = 1'b1;
    branch_to(32'h700);
    repeat (8) tick();
    check_eq("flush_pre_vld", 32'(s_vld), 32'd1);
    clear_logs();
    branch_to(32'h600);
    check_eq("flush_vld", 32'(s_vld), 32'd0);
    ready_i = 1'b1;
    repeat (4) tick();
    drain();
    check_eq("flush_p0_addr", pops[0].addr, 32'h600);
    check_eq("flush_npop", pops.size(), grants.size());

    // Reset with two outstanding: late responses must not surface.
    clear_logs();
    rsp_en = 1'b0; req_i = 1'b1;
    branch_to(32'h800);
    repeat (3) tick();
    check_eq("rst2_busy_pre", 32'(s_busy), 32'd1);
    req_i = 1'b0;
    RST_N = 1'b0;
    tick();
    check_eq("rst2_busy", 32'(s_busy), 32'd0);
    check_eq("rst2_req", 32'(s_req), 32'd0);
    RST_N = 1'b1; rsp_en = 1'b1;
    clear_logs();
    repeat (6) tick();
    check_eq("rst2_npop", pops.size(), 32'd0);
    check_eq("rst2_vld", 32'(s_vld), 32'd0);
    check_eq("rst2_busy_post", 32'(s_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
